data_mem_lsu: RTL
=================

// Module: data_mem_lsu
// PURPOSE
//  Load/store unit upstream of the data port of the memory controller. It accepts one
//  CPU load or store at a time over a valid/ready handshake and range-checks the
//  address against the data window. It drives data_addr/rd_data_en/wr_data_en/wrt_data
//  and captures the synchronous read data. It returns a response (rdata, fault) over a
//  second valid/ready handshake. The instruction port is not touched.
// PARAMETERS
//  ADDR_W      12      address width (matches the memory controller)
//  DATA_W      32      data word width
//  DATA_BASE   12'h400 lowest legal data address (inclusive)
//  DATA_TOP    12'hFFF highest legal data address (inclusive)
//  RD_LATENCY  1       cycles from rd_data_en high to valid data on mem_rdata (>=1)
// PORTS
//  clk        in   1       clock; all logic on the rising edge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       CPU request present
//  req_ready  out  1       LSU can accept a request
//  req_we     in   1       1 = store, 0 = load
//  req_addr   in   ADDR_W  byte/word address as issued by the CPU
//  req_wdata  in   DATA_W  store data
//  resp_valid out  1       response present
//  resp_ready in   1       CPU consumes the response
//  resp_rdata out  DATA_W  load data; 0 for stores and faults
//  resp_fault out  1       address outside [DATA_BASE, DATA_TOP]; no memory access made
//  data_addr  out  ADDR_W  to memory controller data port
//  rd_data_en out  1       read strobe, one cycle per load
//  wr_data_en out  1       write strobe, one cycle per store
//  wrt_data   out  DATA_W  store data to memory
//  mem_rdata  in   DATA_W  read data from memory controller
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_fault=0, data_addr=0,
//    rd_data_en=0, wr_data_en=0, wrt_data=0, wait counter=0. req_ready=0 while rst=1.
//    All outputs except req_ready are registered.
//  req_ready = (state==IDLE) & ~rst. Accept when req_valid & req_ready. On accept, latch
//    we/addr/wdata. A request not accepted may change freely.
//  FSM: IDLE -> ISSUE (legal addr) | RESP (illegal addr); ISSUE -> WAIT (load) | RESP (store);
//    WAIT counts RD_LATENCY cycles, then -> RESP; RESP -> IDLE when resp_ready.
//  ISSUE (1 cycle): data_addr=latched addr. A store drives wr_data_en=1 with
//    wrt_data=latched wdata. A load drives rd_data_en=1. Strobes are high exactly one
//    cycle per access.
//  WAIT: in the last WAIT cycle, sample mem_rdata into resp_rdata.
//  Latency (accept at edge T): fault resp_valid at T+1; store wr_data_en at T+1 and
//    resp_valid at T+2; load rd_data_en at T+1 and resp_valid at T+2+RD_LATENCY.
//  RESP: resp_valid, resp_rdata and resp_fault are held stable until resp_ready=1. Then
//    resp_valid=0 on the next cycle and req_ready=1 again. Peak throughput is one
//    request every 3 cycles (store) or 3+RD_LATENCY cycles (load).
//  Range check: fault iff addr < DATA_BASE or addr > DATA_TOP, compared unsigned at
//    ADDR_W. Both bounds are legal. A fault never asserts rd_data_en or wr_data_en.
//  Reset mid-operation: the in-flight access is dropped and no response is produced. A
//    strobe already high in the cycle rst is sampled still completes in memory; it is
//    low the next cycle.
//  req_valid while busy is ignored (req_ready=0); no queueing.
// TESTING
//  Store 0xDEADBEEF @0x400 then load @0x400: wr_data_en pulse at T+1, load returns
//    rdata=0xDEADBEEF, fault=0.
//  Load @0x3FF, store @0x000: resp_fault=1, rdata=0; rd_data_en/wr_data_en never high.
//  Store/load @0xFFF (upper bound): legal, data round-trips, fault=0.
//  Hold resp_ready=0 for 5 cycles: resp_valid/rdata stable, req_ready=0 throughout;
//    accept the next request only after the handshake.
//  Back-to-back stores to 0x500..0x503 with req_valid held high: exactly 4 wr_data_en
//    pulses, one accept per 3 cycles.
//  Assert rst during load WAIT: no resp_valid, state IDLE, req_ready=1 one cycle
//    after rst deasserts.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Load/store unit for the memory controller data port. It takes one request at a time,
// range-checks the address, issues a single-cycle strobe and returns a held response.
//
//  state   | meaning
//  IDLE    | ready for a request; req_ready high
//  ISSUE   | strobe cycle: rd_data_en or wr_data_en high for exactly one cycle
//  WAIT_RD | load only: down-count read latency, capture mem_rdata on terminal count
//  RESP    | response held stable until resp_ready
module data_mem_lsu #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] DATA_BASE  = 12'h400,
  parameter logic [ADDR_W-1:0] DATA_TOP   = 12'hFFF,
  parameter int                RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] data_addr,
  output logic              rd_data_en,
  output logic              wr_data_en,
  output logic [DATA_W-1:0] wrt_data,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_fault_q, resp_fault_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic              rd_data_en_q, rd_data_en_d;
  logic              wr_data_en_q, wr_data_en_d;
  logic [DATA_W-1:0] wrt_data_q, wrt_data_d;
  logic              addr_fault;

  // One extra bit keeps the compare meaningful even when a bound sits at the range limit.
  assign addr_fault = ({1'b0, req_addr} < {1'b0, DATA_BASE}) ||
                      ({1'b0, req_addr} > {1'b0, DATA_TOP});

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign data_addr  = data_addr_q;
  assign rd_data_en = rd_data_en_q;
  assign wr_data_en = wr_data_en_q;
  assign wrt_data   = wrt_data_q;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    wait_cnt_d   = wait_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    data_addr_d  = data_addr_q;
    wrt_data_d   = wrt_data_q;
    rd_data_en_d = 1'b0;
    wr_data_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_d = req_we;
          if (addr_fault) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            data_addr_d = req_addr;
            if (req_we) begin
              wr_data_en_d = 1'b1;
              wrt_data_d   = req_wdata;
            end else begin
              rd_data_en_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = '0;
        end else begin
          state_d    = WAIT_RD;
          wait_cnt_d = CNT_W'(RD_LATENCY - 1);
        end
      end
      WAIT_RD: begin
        if (wait_cnt_q == '0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = mem_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_fault_d = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      data_addr_q  <= '0;
      rd_data_en_q <= 1'b0;
      wr_data_en_q <= 1'b0;
      wrt_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      wait_cnt_q   <= wait_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      data_addr_q  <= data_addr_d;
      rd_data_en_q <= rd_data_en_d;
      wr_data_en_q <= wr_data_en_d;
      wrt_data_q   <= wrt_data_d;
    end
  end

endmodule
